// File: rtl/pdp_mem_arbiter.sv
// pdp_mem_arbiter: shares the single-port PDP8 main memory between the
// instruction fetch/decode unit (read-only) and the execution unit (read/write).
// Each access runs IDLE -> ISSUE -> (RWAIT) -> IDLE. All outputs are registered.
//
// Optional feature macro: PDP_ARB_RR_EN
//   undefined : contention goes to EXU, but IFD is forced a grant after
//               EXU_MAX_CONSEC consecutive contended EXU wins.
//   defined   : contention resolves round-robin against the last-granted owner.
module pdp_mem_arbiter #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned DATA_W         = 12,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned EXU_MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  // Instruction fetch/decode unit
  input  logic              ifd_req,
  input  logic [ADDR_W-1:0] ifd_addr,
  output logic              ifd_gnt,
  output logic              ifd_rvalid,
  output logic [DATA_W-1:0] ifd_rdata,
  // Execution unit
  input  logic              exu_req,
  input  logic              exu_we,
  input  logic [ADDR_W-1:0] exu_addr,
  input  logic [DATA_W-1:0] exu_wdata,
  output logic              exu_gnt,
  output logic              exu_rvalid,
  output logic [DATA_W-1:0] exu_rdata,
  // Memory
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StRwait = 2'd2;

  localparam logic OwnIfd = 1'b0;
  localparam logic OwnExu = 1'b1;

  localparam logic [2:0] RdLat = 3'(RD_LATENCY);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              ifd_gnt_q, ifd_gnt_d;
  logic              exu_gnt_q, exu_gnt_d;
  logic              ifd_rvalid_q, ifd_rvalid_d;
  logic              exu_rvalid_q, exu_rvalid_d;
  logic [DATA_W-1:0] ifd_rdata_q, ifd_rdata_d;
  logic [DATA_W-1:0] exu_rdata_q, exu_rdata_d;
  logic              pick_exu;

`ifdef PDP_ARB_RR_EN
  logic              last_q, last_d;
`else
  localparam logic [3:0] MaxConsec = 4'(EXU_MAX_CONSEC);
  logic [3:0]        consec_q, consec_d;
`endif

  // Winner selection; only meaningful while in IDLE with a request pending
  always_comb begin
    pick_exu = exu_req & ~ifd_req;
    if (ifd_req && exu_req) begin
`ifdef PDP_ARB_RR_EN
      pick_exu = (last_q == OwnIfd);
`else
      pick_exu = (consec_q != MaxConsec);
`endif
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    ifd_gnt_d    = 1'b0;
    exu_gnt_d    = 1'b0;
    ifd_rvalid_d = 1'b0;
    exu_rvalid_d = 1'b0;
    ifd_rdata_d  = ifd_rdata_q;
    exu_rdata_d  = exu_rdata_q;
`ifdef PDP_ARB_RR_EN
    last_d       = last_q;
`else
    consec_d     = consec_q;
`endif

    case (state_q)
      StIdle: begin
        if (ifd_req || exu_req) begin
          state_d   = StIssue;
          owner_d   = pick_exu ? OwnExu : OwnIfd;
          // IFD is read-only regardless of what exu_we happens to be
          we_d      = pick_exu & exu_we;
          addr_d    = pick_exu ? exu_addr : ifd_addr;
          wdata_d   = pick_exu ? exu_wdata : '0;
          mem_rd_d  = ~(pick_exu & exu_we);
          mem_wr_d  = pick_exu & exu_we;
          ifd_gnt_d = ~pick_exu;
          exu_gnt_d = pick_exu;
`ifdef PDP_ARB_RR_EN
          last_d    = pick_exu ? OwnExu : OwnIfd;
`else
          if (!pick_exu) begin
            consec_d = '0;
          end else if (ifd_req && (consec_q != MaxConsec)) begin
            consec_d = consec_q + 4'd1;
          end
`endif
        end
      end
      StIssue: begin
        if (we_q) begin
          state_d = StIdle;
        end else begin
          state_d = StRwait;
          cnt_d   = RdLat;
        end
      end
      StRwait: begin
        if (cnt_q == 3'd1) begin
          state_d = StIdle;
          if (owner_q == OwnExu) begin
            exu_rdata_d  = mem_rdata;
            exu_rvalid_d = 1'b1;
          end else begin
            ifd_rdata_d  = mem_rdata;
            ifd_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any in-flight read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      owner_q      <= OwnIfd;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      ifd_gnt_q    <= 1'b0;
      exu_gnt_q    <= 1'b0;
      ifd_rvalid_q <= 1'b0;
      exu_rvalid_q <= 1'b0;
      ifd_rdata_q  <= '0;
      exu_rdata_q  <= '0;
`ifdef PDP_ARB_RR_EN
      last_q       <= OwnIfd;
`else
      consec_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      ifd_gnt_q    <= ifd_gnt_d;
      exu_gnt_q    <= exu_gnt_d;
      ifd_rvalid_q <= ifd_rvalid_d;
      exu_rvalid_q <= exu_rvalid_d;
      ifd_rdata_q  <= ifd_rdata_d;
      exu_rdata_q  <= exu_rdata_d;
`ifdef PDP_ARB_RR_EN
      last_q       <= last_d;
`else
      consec_q     <= consec_d;
`endif
    end
  end

  assign ifd_gnt    = ifd_gnt_q;
  assign ifd_rvalid = ifd_rvalid_q;
  assign ifd_rdata  = ifd_rdata_q;
  assign exu_gnt    = exu_gnt_q;
  assign exu_rvalid = exu_rvalid_q;
  assign exu_rdata  = exu_rdata_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// Directed bench for pdp_mem_arbiter. Three instances share the stimulus and
// differ only in RD_LATENCY (1, 3, 7); instance 0 is the primary one.
module tb_pdp_mem_arbiter;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ifd_req, exu_req, exu_we;
  logic [11:0] ifd_addr, exu_addr, exu_wdata;

  logic        ifd_gnt [NI];
  logic        ifd_rvalid [NI];
  logic [11:0] ifd_rdata [NI];
  logic        exu_gnt [NI];
  logic        exu_rvalid [NI];
  logic [11:0] exu_rdata [NI];
  logic        mem_rd [NI];
  logic        mem_wr [NI];
  logic [11:0] mem_addr [NI];
  logic [11:0] mem_wdata [NI];
  logic [11:0] mem_rdata [NI];

  logic [11:0] mem [4096];
  logic        pre_we;
  logic [11:0] pre_addr, pre_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Shared memory array; only instance 0 writes it
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_wr[0]) mem[mem_addr[0]] <= mem_wdata[0];
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned Lat = (g == 0) ? 1 : ((g == 1) ? 3 : 7);
    int          age = 0;
    logic [11:0] raddr = '0;

    // Read data is valid only exactly Lat cycles after mem_rd
    always @(posedge clk) begin
      if (mem_rd[g]) begin
        age   <= 1;
        raddr <= mem_addr[g];
      end else if (age != 0 && age < 15) begin
        age <= age + 1;
      end
    end
    assign mem_rdata[g] = (age == int'(Lat)) ? mem[raddr] : 12'o7070;

    pdp_mem_arbiter #(
      .ADDR_W        (12),
      .DATA_W        (12),
      .RD_LATENCY    (Lat),
      .EXU_MAX_CONSEC(4)
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ifd_req   (ifd_req),
      .ifd_addr  (ifd_addr),
      .ifd_gnt   (ifd_gnt[g]),
      .ifd_rvalid(ifd_rvalid[g]),
      .ifd_rdata (ifd_rdata[g]),
      .exu_req   (exu_req),
      .exu_we    (exu_we),
      .exu_addr  (exu_addr),
      .exu_wdata (exu_wdata),
      .exu_gnt   (exu_gnt[g]),
      .exu_rvalid(exu_rvalid[g]),
      .exu_rdata (exu_rdata[g]),
      .mem_rd    (mem_rd[g]),
      .mem_wr    (mem_wr[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
    );
  end

  function automatic int lat_of(input int g);
    case (g)
      0:       return 1;
      1:       return 3;
      default: return 7;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs(input int g);
    return {ifd_gnt[g], ifd_rvalid[g], ifd_rdata[g], exu_gnt[g], exu_rvalid[g],
            exu_rdata[g], mem_rd[g], mem_wr[g], mem_addr[g], mem_wdata[g]};
  endfunction

  // Advance one cycle and land on the falling edge; check per-cycle invariants
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("rd_wr_overlap[%0d]", g), 64'(mem_rd[g] & mem_wr[g]), 64'd0);
      check($sformatf("double_gnt[%0d]", g), 64'(ifd_gnt[g] & exu_gnt[g]), 64'd0);
    end
  endtask

  task automatic idle_inputs();
    ifd_req   = 1'b0;
    exu_req   = 1'b0;
    exu_we    = 1'b0;
    ifd_addr  = '0;
    exu_addr  = '0;
    exu_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // IFD read seen at c=0; rvalid expected at c = latency + 2 on every instance
  task automatic ifd_read(input string tag, input logic [11:0] a, input logic [11:0] d);
    ifd_req  = 1'b1;
    ifd_addr = a;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin
        check({tag, "_ifd_gnt"}, 64'(ifd_gnt[0]), 64'd1);
        check({tag, "_mem_rd"}, 64'(mem_rd[0]), 64'd1);
        check({tag, "_mem_addr"}, 64'(mem_addr[0]), 64'(a));
        check({tag, "_exu_gnt"}, 64'(exu_gnt[0]), 64'd0);
        ifd_req = 1'b0;
      end
      for (int g = 0; g < NI; g++) begin
        check($sformatf("%s_ifd_rvalid[%0d]c%0d", tag, g, c), 64'(ifd_rvalid[g]),
              64'(c == lat_of(g) + 2));
        check($sformatf("%s_exu_rvalid[%0d]c%0d", tag, g, c), 64'(exu_rvalid[g]), 64'd0);
        if (c == lat_of(g) + 2)
          check($sformatf("%s_ifd_rdata[%0d]", tag, g), 64'(ifd_rdata[g]), 64'(d));
      end
    end
  endtask

  initial begin
    logic [9:0] order;
    int         n;
    logic       exp_exu;

    idle_inputs();
    reset_n  = 1'b0;
    pre_we   = 1'b1;
    pre_addr = 12'o0200;
    pre_data = 12'o1234;
    tick();
    pre_we = 1'b0;
    tick();
    for (int g = 0; g < NI; g++)
      check($sformatf("reset_outputs[%0d]", g), all_outs(g), 64'd0);
    reset_n = 1'b1;
    tick();

    // IFD read plus latency sweep across the three instances
    ifd_read("ifd_read", 12'o0200, 12'o1234);

    // EXU write 7777 -> 0010
    exu_req   = 1'b1;
    exu_we    = 1'b1;
    exu_addr  = 12'o0010;
    exu_wdata = 12'o7777;
    tick();
    check("wr_exu_gnt", 64'(exu_gnt[0]), 64'd1);
    check("wr_mem_wr", 64'(mem_wr[0]), 64'd1);
    check("wr_mem_rd", 64'(mem_rd[0]), 64'd0);
    check("wr_mem_addr", 64'(mem_addr[0]), 64'o0010);
    check("wr_mem_wdata", 64'(mem_wdata[0]), 64'o7777);
    check("wr_ifd_gnt", 64'(ifd_gnt[0]), 64'd0);
    exu_req = 1'b0;
    tick();
    check("wr_one_cycle", 64'(mem_wr[0]), 64'd0);
    check("wr_gnt_pulse", 64'(exu_gnt[0]), 64'd0);

    // EXU read back from the IDLE cycle following the write
    exu_req = 1'b1;
    exu_we  = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) begin
        check("rb_mem_rd", 64'(mem_rd[0]), 64'd1);
        check("rb_exu_gnt", 64'(exu_gnt[0]), 64'd1);
        check("rb_mem_addr", 64'(mem_addr[0]), 64'o0010);
        exu_req = 1'b0;
      end
      for (int g = 0; g < NI; g++) begin
        check($sformatf("rb_exu_rvalid[%0d]k%0d", g, k), 64'(exu_rvalid[g]),
              64'(k == lat_of(g) + 2));
        check($sformatf("rb_ifd_rvalid[%0d]k%0d", g, k), 64'(ifd_rvalid[g]), 64'd0);
        if (k == lat_of(g) + 2)
          check($sformatf("rb_exu_rdata[%0d]", g), 64'(exu_rdata[g]), 64'o7777);
      end
    end
    check("ifd_rdata_held", 64'(ifd_rdata[0]), 64'o1234);

    // Contention: both request continuously from a fresh reset
    do_reset();
    ifd_req   = 1'b1;
    ifd_addr  = 12'o0200;
    exu_req   = 1'b1;
    exu_we    = 1'b1;
    exu_addr  = 12'o0300;
    exu_wdata = 12'o0055;
    order     = 'x;
    n         = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      tick();
      if (exu_gnt[0]) begin
        order[n] = 1'b1;
        n++;
      end else if (ifd_gnt[0]) begin
        order[n] = 1'b0;
        n++;
      end
    end
    check("contention_grant_count", 64'(n), 64'd10);
    for (int i = 0; i < 10; i++) begin
`ifdef PDP_ARB_RR_EN
      exp_exu = (i % 2 == 0);
`else
      exp_exu = (i % 5 != 4);
`endif
      check($sformatf("contention_grant%0d_is_exu", i), 64'(order[i]), 64'(exp_exu));
    end
    idle_inputs();
    repeat (12) tick();

    // Reset asserted while the slow instances sit in RWAIT
    ifd_req  = 1'b1;
    ifd_addr = 12'o0200;
    tick();
    ifd_req = 1'b0;
    tick();
    tick();
    tick();
    check("pre_reset_rdata7", 64'(ifd_rdata[2]), 64'o1234);
    check("pre_reset_addr7", 64'(mem_addr[2]), 64'o0200);
    reset_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++)
      check($sformatf("async_reset_outputs[%0d]", g), all_outs(g), 64'd0);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      for (int g = 0; g < NI; g++)
        check($sformatf("no_rvalid_after_reset[%0d]c%0d", g, c), 64'(ifd_rvalid[g]), 64'd0);
    end
    ifd_read("post_reset", 12'o0200, 12'o1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
